sig_lut_loader: RTL and testbench

Writable sigmoid lookup table, the write-side counterpart of the fixed sigmoid ROM used by the neuron datapath. Accepts a full table image over a valid/ready stream and stores it in an internal array. After the load completes, it serves sigmoid lookups with the same offset-binary addressing the neuron expects. Used to reload activation curves at run time instead of fixing them at synthesis through a memory-init file.

---
 rtl/sig_lut_loader.sv | 160 ++++++++++++++++
 tb/tb_sig_lut_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_lut_loader.sv
// sig_lut_loader: writable sigmoid lookup table.
// A full table image arrives over a valid/ready stream in address order.
// Once a well-formed image is resident, the table serves 1-cycle registered
// lookups using offset-binary addressing (signed x with its MSB inverted).
// Optional build macro SIG_LUT_CHECKSUM_EN enables a 32-bit running sum of
// accepted load words on the checksum port; otherwise checksum is tied to 0.
`timescale 1ns/1ps

module sig_lut_loader #(
  parameter int inWidth   = 10,
  parameter int dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 ld_valid,
  input  logic [dataWidth-1:0] ld_data,
  input  logic                 ld_last,
  output logic                 ld_ready,
  output logic                 table_ready,
  output logic                 load_err,
  input  logic [inWidth-1:0]   x,
  input  logic                 x_valid,
  output logic [dataWidth-1:0] out,
  output logic                 out_valid,
  output logic [31:0]          checksum
);

  localparam int unsigned DEPTH = 2 ** inWidth;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t               state;
  logic [inWidth-1:0]   wr_addr;
  logic [dataWidth-1:0] mem [DEPTH];

  logic                 accept;
  logic                 at_end;
  logic [inWidth-1:0]   rd_addr;
  logic                 rd_en;

  // A restart pulse in LOAD takes priority; a word presented with it is dropped.
  assign accept  = (state == LOAD) && ld_valid && ld_ready && !load_start;
  assign at_end  = (wr_addr == '1);
  // Offset binary: most negative x maps to entry 0, zero to the midpoint.
  assign rd_addr = {~x[inWidth-1], x[inWidth-2:0]};
  // Lookups are only honoured while a complete table is resident.
  assign rd_en   = x_valid && table_ready;

  // Load control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_addr     <= '0;
      ld_ready    <= 1'b0;
      table_ready <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            state    <= LOAD;
            wr_addr  <= '0;
            load_err <= 1'b0;
            ld_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (load_start) begin
            wr_addr <= '0;
          end else if (accept) begin
            wr_addr <= wr_addr + inWidth'(1);
            if (at_end) begin
              ld_ready <= 1'b0;
              if (ld_last) begin
                state       <= READY;
                table_ready <= 1'b1;
              end else begin
                // Image longer than the table.
                state    <= ERR;
                load_err <= 1'b1;
              end
            end else if (ld_last) begin
              // Image shorter than the table; the word itself is still stored.
              state    <= ERR;
              load_err <= 1'b1;
              ld_ready <= 1'b0;
            end
          end
        end
        READY: begin
          if (load_start) begin
            state       <= LOAD;
            wr_addr     <= '0;
            table_ready <= 1'b0;
            ld_ready    <= 1'b1;
          end
        end
        ERR: begin
          if (load_start) begin
            state    <= LOAD;
            wr_addr  <= '0;
            load_err <= 1'b0;
            ld_ready <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          ld_ready    <= 1'b0;
          table_ready <= 1'b0;
        end
      endcase
    end
  end

  // Table write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_addr] <= ld_data;
    end
  end

  // Registered lookup read port; out holds when no valid lookup occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rd_en;
      if (rd_en) begin
        out <= mem[rd_addr];
      end
    end
  end

`ifdef SIG_LUT_CHECKSUM_EN
  logic [31:0] sum_q;

  // Running mod-2^32 sum of accepted words, cleared by every load_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (load_start) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + 32'(ld_data);
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_sig_lut_loader.sv
// Testbench for sig_lut_loader: directed loads and lookups, scoreboard checking.
`timescale 1ns/1ps

module tb_sig_lut_loader;

`ifdef SIG_LUT_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        table_ready;
  logic        load_err;
  logic [9:0]  x;
  logic        x_valid;
  logic [15:0] out;
  logic        out_valid;
  logic [31:0] checksum;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  sig_lut_loader #(.inWidth(10), .dataWidth(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .table_ready(table_ready), .load_err(load_err),
    .x(x), .x_valid(x_valid), .out(out), .out_valid(out_valid),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented output must match the oldest expected lookup.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: out_valid=1 out=0x%0h, no lookup pending", out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out !== mon_exp) begin
          errors++;
          $display("FAIL lookup_data: got 0x%0h expected 0x%0h", out, mon_exp);
        end
      end
    end
  end

  function automatic logic [15:0] pat(int sel, int i);
    case (sel)
      0:       return 16'(i);
      1:       return 16'(i) ^ 16'hA5A5;
      default: return 16'hFFFF - 16'(i);
    endcase
  endfunction

  function automatic logic [31:0] csum(int sel, int n);
    logic [31:0] s = 0;
    for (int i = 0; i < n; i++) s = s + 32'(pat(sel, i));
    return CS_EN ? s : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_word(logic [15:0] d, logic last);
    check("ld_ready_in_load", 32'(ld_ready), 32'd1);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Stream an image; last_at beyond 1023 means ld_last is never raised.
  task automatic full_load(int sel, bit rnd, int last_at, bit do_start);
    int n;
    n = (last_at < 1023) ? last_at + 1 : 1024;
    if (do_start) pulse_start();
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        for (int k = 0; k < 3; k++) begin
          if ($urandom_range(1, 0) == 0) break;
          ld_valid = 1'b0;
          tick();
          check("ld_ready_stall", 32'(ld_ready), 32'd1);
        end
      end
      send_word(pat(sel, i), 1'(i == last_at));
    end
  endtask

  task automatic lookup(logic [9:0] xv, bit expv, logic [15:0] e);
    x       = xv;
    x_valid = 1'b1;
    if (expv) exp_q.push_back(e);
    tick();
  endtask

  task automatic drain();
    x_valid = 1'b0;
    repeat (2) tick();
  endtask

  task automatic readback(int sel);
    for (int a = 0; a < 1024; a++) lookup(10'(a) ^ 10'h200, 1'b1, pat(sel, a));
    drain();
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    ld_last = 1'b0; x = '0; x_valid = 1'b0;
    repeat (2) tick();
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_table_ready", 32'(table_ready), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_checksum", checksum, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_ld_ready", 32'(ld_ready), 32'd0);

    // Identity image, then the three anchor lookups back to back.
    full_load(0, 1'b0, 1023, 1'b1);
    check("t1_table_ready", 32'(table_ready), 32'd1);
    check("t1_load_err", 32'(load_err), 32'd0);
    check("t1_ld_ready", 32'(ld_ready), 32'd0);
    check("t1_checksum", checksum, CS_EN ? 32'd523776 : 32'd0);
    lookup(10'h200, 1'b1, 16'd0);
    lookup(10'h000, 1'b1, 16'd512);
    lookup(10'h1FF, 1'b1, 16'd1023);
    drain();
    readback(0);
    check("t2_checksum_hold", checksum, CS_EN ? 32'd523776 : 32'd0);

    // Short image: ld_last on word 5.
    full_load(1, 1'b0, 5, 1'b1);
    check("t3_load_err", 32'(load_err), 32'd1);
    check("t3_table_ready", 32'(table_ready), 32'd0);
    check("t3_ld_ready", 32'(ld_ready), 32'd0);
    check("t3_checksum", checksum, csum(1, 6));
    lookup(10'h000, 1'b0, 16'd0);
    drain();
    check("t3_err_sticky", 32'(load_err), 32'd1);
    pulse_start();
    check("t3_err_cleared", 32'(load_err), 32'd0);
    check("t3_reload_ready", 32'(ld_ready), 32'd1);
    check("t3_checksum_clr", checksum, 32'd0);

    // Stalled load with random ld_valid gaps.
    full_load(1, 1'b1, 1023, 1'b0);
    check("t4_table_ready", 32'(table_ready), 32'd1);
    check("t4_load_err", 32'(load_err), 32'd0);
    check("t4_checksum", checksum, csum(1, 1024));
    readback(1);

    // Overrun: 1024 words without ld_last.
    full_load(2, 1'b0, 2000, 1'b1);
    check("ovr_load_err", 32'(load_err), 32'd1);
    check("ovr_table_ready", 32'(table_ready), 32'd0);
    check("ovr_checksum", checksum, csum(2, 1024));

    // Reset in the middle of a load.
    pulse_start();
    for (int i = 0; i < 300; i++) send_word(pat(2, i), 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ld_ready", 32'(ld_ready), 32'd0);
    check("mid_rst_table_ready", 32'(table_ready), 32'd0);
    check("mid_rst_load_err", 32'(load_err), 32'd0);
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_checksum", checksum, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    full_load(2, 1'b0, 1023, 1'b1);
    check("t5_table_ready", 32'(table_ready), 32'd1);
    lookup(10'h200, 1'b1, 16'hFFFF);
    lookup(10'h000, 1'b1, 16'hFDFF);
    lookup(10'h1FF, 1'b1, 16'hFC00);
    lookup(10'h3FF, 1'b1, 16'hFE00);
    drain();

    // Reload from READY; lookup alongside load_start is still served.
    load_start = 1'b1;
    lookup(10'h000, 1'b1, 16'hFDFF);
    load_start = 1'b0;
    check("t6_table_dropped", 32'(table_ready), 32'd0);
    x = 10'h000;
    x_valid = 1'b1;
    full_load(0, 1'b0, 1023, 1'b0);
    x_valid = 1'b0;
    check("t6_table_ready", 32'(table_ready), 32'd1);
    lookup(10'h201, 1'b1, 16'd1);
    lookup(10'h3FF, 1'b1, 16'd511);
    lookup(10'h100, 1'b1, 16'd768);
    drain();

    repeat (2) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
